// File: rtl/led_strip_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : led_strip_sequencer
// Brief   : Pads one frame of per-bin LED counts to exactly LEDS (shortfall to
//           the largest bin) and streams one bin index per LED over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module led_strip_sequencer #(
    parameter int LEDS    = 50,
    parameter int BIN_QTY = 12,
    parameter int CW      = $clog2(LEDS),
    parameter int SW      = CW + $clog2(BIN_QTY)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BIN_QTY-1:0][CW-1:0]   LEDCount,
    input  logic                         data_v,
    input  logic                         led_ready,
    output logic [$clog2(BIN_QTY)-1:0]   led_bin,
    output logic [CW-1:0]                led_index,
    output logic                         led_v,
    output logic                         frame_done,
    output logic                         frame_drop,
    output logic                         busy
);

    localparam int c_BW = $clog2(BIN_QTY);
    localparam int c_RW = CW + 1;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_SUM  = 3'd1;
    localparam logic [2:0] c_ST_PAD  = 3'd2;
    localparam logic [2:0] c_ST_LOAD = 3'd3;
    localparam logic [2:0] c_ST_SEND = 3'd4;

    localparam logic [c_BW-1:0] c_PTR_LAST = c_BW'(BIN_QTY - 1);
    localparam logic [c_BW-1:0] c_PTR_ONE  = c_BW'(1);
    localparam logic [CW-1:0]   c_IDX_LAST = CW'(LEDS - 1);
    localparam logic [CW-1:0]   c_IDX_ONE  = CW'(1);
    localparam logic [c_RW-1:0] c_REM_ONE  = c_RW'(1);
    localparam logic [SW-1:0]   c_LEDS_SW  = SW'(LEDS);

    logic [2:0]                 r_state;
    logic [2:0]                 w_state_next;
    logic [BIN_QTY-1:0][CW-1:0] r_cnt;
    logic [SW-1:0]              r_sum;
    logic [CW-1:0]              r_max_val;
    logic [c_BW-1:0]            r_max_idx;
    logic [c_BW-1:0]            r_ptr;
    logic [c_RW-1:0]            r_pad;
    logic [c_RW-1:0]            r_remaining;
    logic [c_RW-1:0]            w_load_rem;
    logic [CW-1:0]              r_led_index;
    logic                       r_led_v;
    logic                       r_frame_done;
    logic                       r_frame_drop;
    logic                       r_busy;
    logic                       w_hs;
    logic                       w_last_beat;
    logic                       w_led_v_d;
    logic                       w_busy_d;
    logic                       w_frame_done_d;
    logic                       w_frame_drop_d;

    assign w_hs        = (r_state == c_ST_SEND) && led_ready;
    assign w_last_beat = (r_led_index == c_IDX_LAST);
    // One extra bit: an all-zero frame loads LEDS into a single bin.
    assign w_load_rem  = {1'b0, r_cnt[r_ptr]} + ((r_ptr == r_max_idx) ? r_pad : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (data_v) w_state_next = c_ST_SUM;
            c_ST_SUM:  if (r_ptr == c_PTR_LAST) w_state_next = c_ST_PAD;
            c_ST_PAD:  w_state_next = c_ST_LOAD;
            c_ST_LOAD: if (w_load_rem != '0) w_state_next = c_ST_SEND;
            c_ST_SEND: begin
                if (w_hs) begin
                    if (w_last_beat) begin
                        w_state_next = c_ST_IDLE;
                    end else if (r_remaining == c_REM_ONE) begin
                        w_state_next = c_ST_LOAD;
                    end
                end
            end
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_led_v_d      = (w_state_next == c_ST_SEND);
        w_busy_d       = (w_state_next != c_ST_IDLE);
        w_frame_done_d = w_hs && w_last_beat;
        w_frame_drop_d = data_v && (r_state != c_ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_sum        <= '0;
            r_max_val    <= '0;
            r_max_idx    <= '0;
            r_ptr        <= '0;
            r_pad        <= '0;
            r_remaining  <= '0;
            r_led_index  <= '0;
            r_led_v      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_drop <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_led_v      <= w_led_v_d;
            r_busy       <= w_busy_d;
            r_frame_done <= w_frame_done_d;
            r_frame_drop <= w_frame_drop_d;
            case (r_state)
                c_ST_IDLE: begin
                    if (data_v) begin
                        r_cnt       <= LEDCount;
                        r_sum       <= '0;
                        r_max_val   <= '0;
                        r_max_idx   <= '0;
                        r_ptr       <= '0;
                        r_led_index <= '0;
                    end
                end
                c_ST_SUM: begin
                    r_sum <= r_sum + SW'(r_cnt[r_ptr]);
                    // Strictly greater keeps the lowest index on ties.
                    if (r_cnt[r_ptr] > r_max_val) begin
                        r_max_val <= r_cnt[r_ptr];
                        r_max_idx <= r_ptr;
                    end
                    r_ptr <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + c_PTR_ONE;
                end
                c_ST_PAD: begin
                    r_pad <= (r_sum < c_LEDS_SW) ? c_RW'(c_LEDS_SW - r_sum) : '0;
                end
                c_ST_LOAD: begin
                    if (w_load_rem == '0) begin
                        r_ptr <= r_ptr + c_PTR_ONE;
                    end else begin
                        r_remaining <= w_load_rem;
                    end
                end
                c_ST_SEND: begin
                    if (w_hs) begin
                        r_remaining <= r_remaining - c_REM_ONE;
                        if (w_last_beat) begin
                            r_led_index <= '0;
                            r_ptr       <= '0;
                        end else begin
                            r_led_index <= r_led_index + c_IDX_ONE;
                            if (r_remaining == c_REM_ONE) begin
                                r_ptr <= r_ptr + c_PTR_ONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign led_bin    = r_ptr;
    assign led_index  = r_led_index;
    assign led_v      = r_led_v;
    assign frame_done = r_frame_done;
    assign frame_drop = r_frame_drop;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/led_strip_sequencer.md
# led_strip_sequencer

Downstream of the LED count calculation stage. Takes one frame of per-bin LED counts, which sum to LEDS or slightly less, and fixes the sum to exactly LEDS by giving the shortfall to the largest bin. It then streams one bin index per physical LED, LED 0 first, over a valid/ready handshake to the LED colour/driver stage.

## Interface
Parameters:
- LEDS, 50: LEDs per frame; every frame emits exactly LEDS beats.
- BIN_QTY, 12: number of note bins.
- CW, $clog2(LEDS): width of one bin count.
- SW, CW + $clog2(BIN_QTY): sum accumulator width.

Ports (one clock; reset is asynchronous and active-high):
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- LEDCount, input, [BIN_QTY-1:0][CW-1:0]: per-bin counts from the upstream stage.
- data_v, input, 1: single-cycle pulse; LEDCount is valid this cycle.
- led_ready, input, 1: downstream can accept a beat.
- led_bin, output, $clog2(BIN_QTY): bin index of the current LED.
- led_index, output, CW: position of the current LED, 0..LEDS-1.
- led_v, output, 1: led_bin/led_index are valid.
- frame_done, output, 1: one-cycle pulse after the last beat of a frame.
- frame_drop, output, 1: one-cycle pulse when data_v arrives while busy.
- busy, output, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, SUM, PAD, LOAD, SEND.
- IDLE
  - On data_v: capture LEDCount into an internal register array. Clear sum, max value, max index, bin pointer and led_index. Go to SUM.
- SUM
  - One bin per cycle, pointer 0..BIN_QTY-1.
  - Add count to the SW-bit sum.
  - Update the max only on strictly greater, so ties resolve to the lowest index.
  - After bin BIN_QTY-1, reset the pointer to 0 and go to PAD.
- PAD
  - pad = LEDS - sum if sum < LEDS, else 0 (saturating, no wrap).
  - Go to LOAD.
- LOAD (led_v low)
  - remaining = count[ptr], plus pad if ptr == max index.
  - If remaining == 0: increment ptr and stay in LOAD.
  - Else go to SEND.
- SEND (led_v high, led_bin = ptr)
  - On led_v && led_ready: decrement remaining and increment led_index.
  - If the accepted beat had led_index == LEDS-1: go to IDLE and pulse frame_done next cycle.
  - Else if remaining reaches 0: increment ptr and go to LOAD.
- Overshoot: if sum > LEDS, the frame still ends after LEDS beats. Remaining tail counts are discarded.
- All-zero frame: pad = LEDS, assigned to bin 0.
- led_bin and led_index stay stable while led_v && !led_ready. led_v never drops without a handshake.
- data_v while busy: input ignored, frame_drop pulses, the current frame is unaffected.
- Reset values (also apply on mid-frame reset): state IDLE, outputs led_v, frame_done, frame_drop, busy, led_bin and led_index all 0. The partial frame is abandoned and no frame_done is issued.

## Timing
- data_v at cycle t: SUM occupies t+1..t+BIN_QTY, PAD is at t+BIN_QTY+1, the first LOAD at t+BIN_QTY+2.
- With bin 0 nonzero, the first led_v is at t+BIN_QTY+3 (t+15 at defaults).
- Each bin costs one LOAD bubble cycle. With led_ready held high, the frame spans BIN_QTY+1+BIN_QTY+LEDS cycles after t (75 at defaults). Bins after the frame's LEDS-th beat get no LOAD cycle.
- frame_done is high the cycle after the final handshake. busy is low in that same cycle.
- A data_v in the frame_done cycle is accepted.
- All outputs are registered.

## Test plan
- All counts 4 (sum 48), led_ready=1:
  - Bin 0 emits 6 beats, bins 1..11 emit 4 beats each, 50 beats in total.
  - First led_v at t+15. frame_done once, at the cycle after the 50th beat.
- Counts {0,0,10,0,30,9,0...} (sum 49):
  - Bin 4 gets 31 beats.
  - Emit order: bin 2 ×10, bin 4 ×31, bin 5 ×9.
  - Zero bins emit nothing.
- All zero:
  - 50 beats of led_bin 0, led_index 0..49.
- Overshoot, counts {30,25,0...}:
  - 30 beats of bin 0, then 20 beats of bin 1, then IDLE.
- Random led_ready backpressure on the first test:
  - Outputs hold while stalled, no beat is lost or duplicated.
  - The led_index sequence is contiguous 0..49.
- data_v pulsed mid-SEND:
  - frame_drop pulses, the current frame completes unchanged.
- rst asserted mid-SEND:
  - All outputs go to 0 immediately.
  - The next data_v starts a fresh frame beginning at led_index 0.
